// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic engine.
package arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Counter must hold values 0..width so a WIDTH-cycle run can be sequenced.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell; the only arithmetic element in the serial engine.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub controller: streams WIDTH operand bits LSB first through one
// full-adder cell and presents sum, carry and signed overflow on a valid/ready port.
module serial_add_ctrl
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shifted;

  fulladder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_shifted = fa_s;
  end else begin : g_sum_wn
    assign sum_shifted = {fa_s, sum_sh_q[WIDTH-1:1]};
  end

  assign last_bit = (state_q == StRun) && (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_valid) state_d = StRun;
      StRun:   if (last_bit)    state_d = StDone;
      StDone:  if (done_ready)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend on state only, so there is no input-to-output path.
  always_comb begin
    start_ready = (state_q == StIdle);
    done_valid  = (state_q == StDone);
    busy        = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          // Subtraction is a + ~b + 1: invert b and force the initial carry.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shifted;
        carry_d  = fa_co;
        cnt_d    = last_bit ? '0 : cnt_q + CNT_W'(1);
        if (last_bit) begin
          // carry_q is the carry into the MSB on this cycle.
          sum_d  = sum_shifted;
          cout_d = fa_co;
          ovf_d  = carry_q ^ fa_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  cnt_in_range_a : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StRun) |-> (cnt_q <= CNT_W'(WIDTH - 1)));

  result_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDone) |=> ($stable(sum_q) && $stable(cout_q) && $stable(ovf_q)));

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor controller that time-shares one 1-bit full-adder cell across a WIDTH-bit operation.
- Accepts operands through a valid/ready handshake and feeds the cell one bit per cycle, LSB first, through a carry flop.
- Collects sum bits and presents the result with carry and overflow on a second valid/ready handshake.
- Gives the arithmetic datapath a low-area add/sub engine for non-time-critical paths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  operation request
start_ready  out  1  controller can accept request
a  in  WIDTH  operand A, sampled at accept
b  in  WIDTH  operand B, sampled at accept
cin  in  1  carry-in for add, sampled at accept
sub  in  1  1 = compute a - b, 0 = a + b + cin; sampled at accept
sum  out  WIDTH  result
cout  out  1  carry out of MSB (for sub: 1 = no borrow)
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
done_valid  out  1  result valid
done_ready  in  1  consumer accepts result
busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, sum=0, cout=0, ovf=0, done_valid=0, busy=0, start_ready=1. Internal shift registers, carry flop and counter are all 0.
- States: IDLE, RUN, DONE, one-hot or binary (implementer's choice).
  - IDLE: start_ready=1. On start_valid at an edge:
    - load a_sh<=a;
    - load b_sh<=(sub ? ~b : b);
    - set carry<=(sub ? 1 : cin);
    - set cnt<=0 and go to RUN.
  - RUN: each cycle the cell computes s, co from a_sh[0], b_sh[0], carry.
    - At the edge: shift a_sh and b_sh right, shift sum_sh right with s entering the MSB, carry<=co, cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1, also capture:
      - cout<=co;
      - ovf<=carry XOR co (carry here is the carry into the MSB);
      - sum<=final sum_sh.
    - Then go to DONE.
  - DONE: done_valid=1. sum, cout and ovf are held stable. On done_ready at an edge: done_valid<=0, go to IDLE.
- Latency: accept at edge T0 gives done_valid=1 after edge T0+WIDTH. Minimum issue interval is WIDTH+2 cycles. start_ready is combinational from state only; there is no input-to-output combinational path.
- sum, cout and ovf keep the last result after leaving DONE, until the next result is captured.
- Boundaries:
  - start_valid in RUN or DONE: ignored, not queued; start_ready=0.
  - a, b, cin and sub changing after accept: no effect.
  - done_ready asserted outside DONE: ignored.
  - done_ready held high permanently: returns to IDLE one cycle after entering DONE.
  - WIDTH=1: exactly one RUN cycle; ovf equals carry-in XOR cout.
  - rst_n asserted mid-RUN or in DONE: immediate return to reset values. No partial result is ever presented.
  - cnt never exceeds WIDTH-1 in RUN. No wrap-around states exist.

Decomposition:
- Shared package (arith_pkg):
  - state enum {IDLE, RUN, DONE};
  - a localparam for the default WIDTH;
  - a function computing CNT_W.
- One sub-module: the existing 1-bit `fulladder` cell (ports s, co, a, b, cin), instantiated once as the sole arithmetic element. The controller contains no '+' operator on datapath bits.
- All sequencing, shift registers and capture logic sit in serial_add_ctrl.

Test Plan:
- WIDTH=8, add a=0x5A, b=0x3C, cin=0 -> after 8 RUN cycles: sum=0x96, cout=0, ovf=1, done_valid asserted at T0+8.
- add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then add a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, ovf=0.
- sub a=0x10, b=0x20, cin=1 (ignored) -> sum=0xF0, cout=0, ovf=0. Then sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Hold done_ready=0 for 5 cycles after done_valid, and pulse start_valid with new operands during RUN and DONE -> result stable, start_ready=0, request dropped. done_ready=1 -> IDLE next cycle, then a fresh request is accepted.
- Assert rst_n=0 on RUN cycle 3 of a=0xAA+b=0x55 -> all outputs 0, start_ready=1 asynchronously. After release, a=0x01+b=0x01 gives sum=0x02 with no residue from the aborted op.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0, done_valid at T0+1. Also run a random 1000-op scoreboard at WIDTH=8 and WIDTH=13 against a behavioural add/sub model.
